// File: rtl/bank_sram_read_issue.sv
// Read issue stage: expands one multi-beat request into per-beat, per-bank linear addresses.
// Optional per-ID busy scoreboard is compiled in with `define BANK_READ_ISSUE_SCOREBOARD_EN.
//
// state | meaning
// IDLE  | waiting for a request; req_ack may assert
// ISSUE | presenting beats on addrout until the retire beat is consumed
module bank_sram_read_issue #(
   parameter int NDATA    = 32,
   parameter int NBANK    = 16,
   parameter int ID_BW    = 2,
   parameter int NBEAT_BW = 4,
   parameter int XOR_BW   = 2,
   localparam int CLOG2_NBANK  = $clog2(NBANK),
   localparam int CCLOG2_NBANK = $clog2(CLOG2_NBANK + 1),
   localparam int ABW          = $clog2(NDATA) + CLOG2_NBANK
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   input  logic                                   req_rdy,
   output logic                                   req_ack,
   input  logic [ID_BW-1:0]                       i_id,
   input  logic [ABW-1:0]                         i_base,
   input  logic [ABW-1:0]                         i_stride,
   input  logic [NBEAT_BW-1:0]                    i_nbeat,
   input  logic [XOR_BW-1:0][CLOG2_NBANK-1:0]     i_xor_src,
   input  logic [CCLOG2_NBANK-1:0]                i_xor_swap,
   output logic                                   addrout_rdy,
   input  logic                                   addrout_ack,
   output logic [ID_BW-1:0]                       o_id,
   output logic [NBANK-1:0][ABW-1:0]              o_raddr,
   output logic                                   o_retire,
   output logic [XOR_BW-1:0][CLOG2_NBANK-1:0]     o_xor_src,
   output logic [CCLOG2_NBANK-1:0]                o_xor_swap,
   input  logic                                   free_dval,
   input  logic [ID_BW-1:0]                       i_free_id,
   output logic [2**ID_BW-1:0]                    o_busy
);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [ABW-1:0]        cur, stride;
   logic [NBEAT_BW-1:0]   remain;
   logic                  id_free;
   logic                  beat_adv;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ack   = 1'b0;
      case (state)
         IDLE: begin
            if (req_rdy && id_free) begin
               req_ack   = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (addrout_ack && (remain == '0)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign addrout_rdy = (state == ISSUE);
   assign o_retire    = (state == ISSUE) && (remain == '0);
   assign beat_adv    = (state == ISSUE) && addrout_ack && (remain != '0);

   // o_raddr is its own register so it reads 0 out of reset and holds through IDLE
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cur        <= '0;
         remain     <= '0;
         stride     <= '0;
         o_id       <= '0;
         o_xor_src  <= '0;
         o_xor_swap <= '0;
         o_raddr    <= '0;
      end else if (req_ack) begin
         cur        <= i_base;
         remain     <= i_nbeat;
         stride     <= i_stride;
         o_id       <= i_id;
         o_xor_src  <= i_xor_src;
         o_xor_swap <= i_xor_swap;
         for (int j = 0; j < NBANK; j++) o_raddr[j] <= i_base + ABW'(j);
      end else if (beat_adv) begin
         cur    <= cur + stride;
         remain <= remain - 1'b1;
         for (int j = 0; j < NBANK; j++) o_raddr[j] <= cur + stride + ABW'(j);
      end
   end

`ifdef BANK_READ_ISSUE_SCOREBOARD_EN
   logic [2**ID_BW-1:0] busy, busy_nxt;

   // set is applied after clear so a same-cycle collision leaves the ID busy
   always_comb begin
      busy_nxt = busy;
      if (free_dval) busy_nxt[i_free_id] = 1'b0;
      if (req_ack)   busy_nxt[i_id]      = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) busy <= '0;
      else        busy <= busy_nxt;
   end

   assign id_free = !busy[i_id];
   assign o_busy  = busy;
`else
   logic unused_free;
   assign unused_free = free_dval ^ (^i_free_id);
   assign id_free     = 1'b1;
   assign o_busy      = '0;
`endif

endmodule
